// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    // ISSUE: may send a request; WAIT_RSP: one live fetch outstanding;
    // DRAIN: one killed fetch outstanding whose response must be swallowed.
    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid, instruction, PC and PC+4 with load/bubble/hold.
// Latency: 1 cycle from load/bubble to outputs.
// Backpressure: holds contents whenever neither load nor bubble is asserted; bubble wins over load.
module if_id_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    import rv32i_pkg::*;

    // Register update: bubble kills the slot, load captures a new instruction, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid    <= 1'b0;
            instr    <= RV32I_NOP;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= RV32I_NOP;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, single-outstanding imem fetch FSM, one-entry hold buffer, IF/ID register.
// Latency: IF/ID loads 1 cycle after imem_rvalid_i; zero-wait memory gives 1 instr every 2 cycles.
// Backpressure: stall_i parks a response in the hold buffer and blocks new requests; flush_i kills everything.
// Optional: define FETCH_STAGE_PERF_CNT_EN to add perf_fetch_o / perf_bubble_o counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_bubble_o
`endif
);
    import rv32i_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic            hold_v_q;
    logic [31:0]     hold_instr_q;
    logic [XLEN-1:0] hold_pc_q;

    logic            accept;
    logic            rsp_live;
    logic            ifid_load;
    logic            ifid_bubble;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] target_aligned;

    // Redirect targets are word addresses; the two low bits are dropped.
    assign target_aligned = pc_target_i & ~XLEN'(3);

    // Requests are gated by reset so nothing leaks out while the stage is held in reset.
    assign imem_req_o  = rst_ni && (state_q == ISSUE) && !hold_v_q && !flush_i;
    assign imem_addr_o = pc_q;
    assign accept      = imem_req_o && imem_ready_i;

    // A response is usable only when it belongs to a live fetch and no redirect kills it.
    assign rsp_live    = (state_q == WAIT_RSP) && imem_rvalid_i && !flush_i;

    // Buffered data always beats a new response: the hold buffer is only full when nothing is in flight.
    assign ifid_load   = !flush_i && !stall_i && (hold_v_q || rsp_live);
    assign ifid_bubble = flush_i || (!stall_i && !hold_v_q && !rsp_live);
    assign ifid_instr  = hold_v_q ? hold_instr_q : imem_rdata_i;
    assign ifid_pc     = hold_v_q ? hold_pc_q    : fetch_pc_q;

    // Next-state: a response always returns to ISSUE; a redirect with a fetch still owed goes to DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE:    if (accept) state_d = WAIT_RSP;
            WAIT_RSP: begin
                if (imem_rvalid_i)  state_d = ISSUE;
                else if (flush_i)   state_d = DRAIN;
            end
            DRAIN:    if (imem_rvalid_i) state_d = ISSUE;
            default:  state_d = ISSUE;
        endcase
    end

    // FSM, PC and the PC of the outstanding fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                pc_q <= target_aligned;
            end else if (accept) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (accept) begin
                fetch_pc_q <= pc_q;
            end
        end
    end

    // Hold buffer: catches a response that arrives while decode is stalled, empties on the first free cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_v_q     <= 1'b0;
            hold_instr_q <= RV32I_NOP;
            hold_pc_q    <= '0;
        end else if (flush_i) begin
            hold_v_q <= 1'b0;
        end else if (rsp_live && stall_i) begin
            hold_v_q     <= 1'b1;
            hold_instr_q <= imem_rdata_i;
            hold_pc_q    <= fetch_pc_q;
        end else if (hold_v_q && !stall_i) begin
            hold_v_q <= 1'b0;
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .load_instr (ifid_instr),
        .load_pc    (ifid_pc),
        .valid      (valid_o),
        .instr      (instr_o),
        .pc         (pc_o),
        .pc_plus4   (pc_plus4_o)
    );

`ifdef FETCH_STAGE_PERF_CNT_EN
    // Event counters: every IF/ID load of a live instruction and every bubble written (flush included).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            if (ifid_load)   perf_fetch_o  <= perf_fetch_o + 32'd1;
            if (ifid_bubble) perf_bubble_o <= perf_bubble_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, fetch scoreboard, redirect vector table.
// Latency: checks IF/ID one cycle after each response and request/response spacing.
// Backpressure: exercises stall_i hold buffer, imem_ready_i low and flush_i redirects.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] pc_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef FETCH_STAGE_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_bubble_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .pc_target_i   (pc_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
`ifdef FETCH_STAGE_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_bubble_o (perf_bubble_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          mode;   // 0: flush in ISSUE, 1: flush in WAIT_RSP without rvalid, 2: flush+rvalid+stall
        int          lat;
        logic [31:0] target;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] p4;
    } vec_t;
    vec_t tv[6];

    // memory model state
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = '0;

    // per-cycle observations
    bit          acc;
    bit          ld;
    logic [31:0] acc_addr;
    logic        last_valid;
    logic [31:0] last_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle. Entered at posedge+1 with inputs already set for this cycle.
    task automatic cycle();
        bit          st;
        bit          fl;
        bit          rv;
        logic [31:0] a;
        #2;
        acc      = imem_req_o & imem_ready_i;
        a        = imem_addr_o;
        acc_addr = a;
        fl       = flush_i;
        st       = stall_i;
        rv       = imem_rvalid_i;
        if (acc) sb.push_back('{pc: a, instr: instr_of(a)});
        @(posedge clk_i);
        #1;
        ld = 1'b0;
        if (rv) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat - 1;
            mem_addr = a;
        end
        if (mem_pend && mem_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(mem_addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
            if (mem_pend) mem_cnt--;
        end
        if (fl) begin
            sb.delete();
            chk("flush_bubble_valid", {31'd0, valid_o}, 32'd0);
            chk("flush_bubble_instr", instr_o, NOP);
        end else if (st) begin
            chk("stall_hold_valid", {31'd0, valid_o}, {31'd0, last_valid});
            chk("stall_hold_pc", pc_o, last_pc);
        end else if (valid_o) begin
            ld = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_load: pc_o %h loaded with no fetch owed", pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("load_pc", pc_o, e.pc);
                chk("load_instr", instr_o, e.instr);
                chk("load_pc_plus4", pc_plus4_o, e.pc + 32'd4);
            end
        end else begin
            chk("bubble_instr", instr_o, NOP);
        end
        last_valid = valid_o;
        last_pc    = pc_o;
    endtask

    task automatic wait_acc(input string name, input bit do_chk, input logic [31:0] exp_addr);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (acc) begin
                if (do_chk) chk(name, acc_addr, exp_addr);
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL %s: no request accepted within 40 cycles, required addr %h", name, exp_addr);
    endtask

    task automatic wait_load(input string name);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (ld) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: no IF/ID load within 40 cycles, required one", name);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (imem_req_o === 1'b1) return;
            cycle();
        end
        checks++;
        failures++;
        $display("FAIL %s: imem_req_o never rose within 40 cycles", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  {31'd0, valid_o},    32'd0);
        chk({tag, "_instr"},  instr_o,             NOP);
        chk({tag, "_pc"},     pc_o,                32'd0);
        chk({tag, "_plus4"},  pc_plus4_o,          32'd0);
        chk({tag, "_req"},    {31'd0, imem_req_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{0, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
        tv[1] = '{1, 3, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
        tv[2] = '{2, 1, 32'h0000_0240, 32'h0000_0240, 32'h0000_0244, 32'h0000_0244};
        tv[3] = '{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        tv[4] = '{1, 2, 32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'h0000_0204};
        tv[5] = '{2, 1, 32'h8000_0001, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};

        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        pc_target_i   = '0;
        imem_ready_i  = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_ni     = 1'b1;
        last_valid = valid_o;
        last_pc    = pc_o;

        // Zero-wait memory after reset: 0x0, then 0x4, one instruction every two cycles.
        cycle();
        chk("first_accept", {31'd0, acc}, 32'd1);
        chk("first_addr", acc_addr, 32'h0);
        chk("valid_before_rsp", {31'd0, valid_o}, 32'd0);
        cycle();
        chk("valid_after_rsp", {31'd0, valid_o}, 32'd1);
        chk("first_pc", pc_o, 32'h0);
        cycle();
        chk("second_accept", {31'd0, acc}, 32'd1);
        chk("second_addr", acc_addr, 32'h4);
        chk("interleave_bubble", {31'd0, valid_o}, 32'd0);
        cycle();
        chk("second_pc", pc_o, 32'h4);

        // Stall across the response for 0x8: IF/ID keeps 0x4, no new request, then 0x8 drains.
        stall_i = 1'b1;
        cycle();
        chk("third_addr", acc_addr, 32'h8);
        chk("third_accept", {31'd0, acc}, 32'd1);
        cycle();
        repeat (3) begin
            #1;
            chk("hold_no_req", {31'd0, imem_req_o}, 32'd0);
            cycle();
            chk("hold_pc", pc_o, 32'h4);
        end
        stall_i = 1'b0;
        #1;
        chk("hold_drain_no_req", {31'd0, imem_req_o}, 32'd0);
        cycle();
        chk("drain_pc", pc_o, 32'h8);
        chk("drain_valid", {31'd0, valid_o}, 32'd1);
        wait_acc("after_hold_addr", 1'b1, 32'hC);
        wait_load("after_hold_load");

        // Memory not ready: request stays up with a stable address.
        wait_req("bp_req");
        imem_ready_i = 1'b0;
        repeat (3) begin
            cycle();
            chk("bp_no_accept", {31'd0, acc}, 32'd0);
            chk("bp_addr_stable", acc_addr, 32'h10);
        end
        imem_ready_i = 1'b1;
        wait_acc("bp_release_addr", 1'b1, 32'h10);
        wait_load("bp_release_load");

        // Redirect vectors.
        for (int k = 0; k < 6; k++) begin
            mem_lat = tv[k].lat;
            if (tv[k].mode == 0) wait_req("row_align_req");
            else                 wait_acc("row_align_acc", 1'b0, 32'h0);
            if (tv[k].mode == 2) stall_i = 1'b1;
            flush_i     = 1'b1;
            pc_target_i = tv[k].target;
            cycle();
            chk("row_flush_no_accept", {31'd0, acc}, 32'd0);
            flush_i     = 1'b0;
            stall_i     = 1'b0;
            pc_target_i = 32'h0BAD_0BAC;
            if (tv[k].mode == 1) begin
                #1;
                chk("row_drain_no_req", {31'd0, imem_req_o}, 32'd0);
            end
            wait_acc("row_addr0", 1'b1, tv[k].a0);
            wait_load("row_load0");
            chk("row_pc", pc_o, tv[k].a0);
            chk("row_pc_plus4", pc_plus4_o, tv[k].p4);
            wait_acc("row_addr1", 1'b1, tv[k].a1);
        end

        // Asynchronous reset in the middle of an outstanding fetch.
        mem_lat = 3;
        wait_acc("pre_reset_acc", 1'b0, 32'h0);
        #2;
        rst_ni = 1'b0;
        sb.delete();
        mem_pend      = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        mem_lat    = 1;
        last_valid = valid_o;
        last_pc    = pc_o;
        wait_acc("refetch_addr", 1'b1, 32'h0);
        wait_load("refetch_load");
        chk("refetch_pc", pc_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
